uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 71 +++++++
 tb/tb_uart_rx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1-style framing with a framing-error pulse
module uart_rx #(
  parameter int DataWidth      = 8,
  parameter int OversampleRate = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 rxd_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 dv_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);
  localparam int TW = $clog2(OversampleRate);
  localparam int BW = DataWidth > 2 ? $clog2(DataWidth) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state;
  logic [1:0]           sync;
  logic                 rxd_s, rxd_s_prev, mid, last;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DataWidth-1:0] shreg;
  assign rxd_s  = sync[1];
  assign busy_o = state != IDLE;
  assign mid    = tick_i && tcnt == TW'(OversampleRate / 2 - 1);
  assign last   = tick_i && tcnt == TW'(OversampleRate - 1);
  // Synchroniser, edge register and frame FSM; counters advance only on ticks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync        <= 2'b11;
      rxd_s_prev  <= 1'b1;
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data_o      <= '0;
      dv_o        <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync        <= {sync[0], rxd_i};
      rxd_s_prev  <= rxd_s;
      dv_o        <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: if (rxd_s_prev && !rxd_s) begin
          tcnt  <= '0;
          state <= START;
        end
        START: if (mid) begin
          tcnt  <= '0;
          bcnt  <= '0;
          state <= rxd_s ? IDLE : DATA;
        end else if (tick_i) tcnt <= tcnt + TW'(1);
        DATA: if (last) begin
          shreg <= DataWidth'({rxd_s, shreg} >> 1);
          tcnt  <= '0;
          bcnt  <= bcnt == BW'(DataWidth - 1) ? bcnt : bcnt + BW'(1);
          state <= bcnt == BW'(DataWidth - 1) ? STOP : DATA;
        end else if (tick_i) tcnt <= tcnt + TW'(1);
        STOP: if (last) begin
          dv_o        <= rxd_s;
          frame_err_o <= !rxd_s;
          data_o      <= rxd_s ? shreg : data_o;
          state       <= IDLE;
        end else if (tick_i) tcnt <= tcnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx (8-bit and 7-bit instances)
module tb_uart_rx;
  localparam int OSR = 16;
  typedef struct {bit err; logic [7:0] d;} exp_t;
  logic clk = 0, rst, tick, rxd, rxd7;
  logic [7:0] data;
  logic [6:0] data7;
  logic dv, fe, busy, dv7, fe7, busy7;
  int div = 4, tcnt = 0, checks = 0, fails = 0;
  logic [7:0] last_good = 0, last_good7 = 0;
  exp_t q[$], q7[$];

  uart_rx #(.DataWidth(8), .OversampleRate(OSR)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .rxd_i(rxd),
    .data_o(data), .dv_o(dv), .frame_err_o(fe), .busy_o(busy));
  uart_rx #(.DataWidth(7), .OversampleRate(OSR)) dut7 (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .rxd_i(rxd7),
    .data_o(data7), .dv_o(dv7), .frame_err_o(fe7), .busy_o(busy7));

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = tcnt == 0;
    tcnt = tcnt + 1 >= div ? 0 : tcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dv || fe) begin
      if (q.size() == 0) chk("unexpected_output8", {dv, fe, 22'd0, data}, 32'd0);
      else begin
        e = q.pop_front();
        chk("out8", {dv, fe, 22'd0, data}, {!e.err, e.err, 22'd0, e.d});
      end
    end
    if (dv7 || fe7) begin
      if (q7.size() == 0) chk("unexpected_output7", {dv7, fe7, 23'd0, data7}, 32'd0);
      else begin
        e = q7.pop_front();
        chk("out7", {dv7, fe7, 23'd0, data7}, {!e.err, e.err, 23'd0, e.d[6:0]});
      end
    end
  end

  task automatic drive_bit(input bit w7, input bit b);
    if (w7) rxd7 = b;
    else rxd = b;
    repeat (OSR * div) @(negedge clk);
  endtask

  task automatic send_frame(input bit w7, input logic [7:0] d, input bit stop);
    int n = w7 ? 7 : 8;
    logic [7:0] m = w7 ? (d & 8'h7f) : d;
    if (w7) begin
      q7.push_back('{err: !stop, d: stop ? m : last_good7});
      if (stop) last_good7 = m;
    end else begin
      q.push_back('{err: !stop, d: stop ? m : last_good});
      if (stop) last_good = m;
    end
    drive_bit(w7, 1'b0);
    chk(w7 ? "busy7_in_frame" : "busy_in_frame", {31'd0, w7 ? busy7 : busy}, 32'd1);
    for (int i = 0; i < n; i++) drive_bit(w7, m[i]);
    drive_bit(w7, stop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    bit prev_err;
    rst = 1; rxd = 1; rxd7 = 1;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {dv, fe, busy, 21'd0, data}, 32'd0);
    chk("reset_outputs7", {dv7, fe7, busy7, 22'd0, data7}, 32'd0);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    send_frame(0, 8'h55, 1);
    repeat (4) @(negedge clk);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("data_hold_55", {24'd0, data}, 32'h55);
    send_frame(0, 8'hA3, 1);
    send_frame(0, 8'h0F, 1);
    rxd = 0;
    repeat (4 * div) @(negedge clk);
    rxd = 1;
    repeat (8 * div + 8) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    send_frame(0, 8'h3C, 0);
    repeat (3 * OSR * div) @(negedge clk);
    chk("held_low_busy", {31'd0, busy}, 32'd0);
    chk("err_data_hold", {24'd0, data}, 32'h0F);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    rst = 1;
    #1;
    chk("midframe_reset", {dv, fe, busy, 21'd0, data}, 32'd0);
    q.delete();
    last_good = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    drive_bit(0, 1'b1);
    send_frame(0, 8'h81, 1);
    prev_err = 0;
    for (int k = 0; k < 24; k++) begin
      bit stop = $urandom_range(0, 5) != 0;
      int gap = prev_err ? 1 : $urandom_range(0, 2);
      div = $urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) ? 2 : 4);
      for (int g = 0; g < gap; g++) drive_bit(0, 1'b1);
      send_frame(0, 8'($urandom), stop);
      prev_err = !stop;
    end
    drive_bit(0, 1'b1);
    div = 4;
    drive_bit(1, 1'b1);
    send_frame(1, 8'h7F, 1);
    send_frame(1, 8'h2A, 0);
    drive_bit(1, 1'b1);
    send_frame(1, 8'h15, 1);
    drive_bit(1, 1'b1);
    repeat (10) @(negedge clk);
    chk("queue8_drained", q.size(), 32'd0);
    chk("queue7_drained", q7.size(), 32'd0);
    chk("final_busy", {30'd0, busy, busy7}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
